rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 141 ++++++++++++++
 tb/tb_rom_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-ported ROM.
// Define ARB_RR_EN for round-robin arbitration; default is data-over-fetch priority.
module rom_arbiter #(
  parameter int ACCESS_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       f_req,
  input  logic [7:0] f_addr,
  output logic       f_gnt,
  output logic       f_valid,
  input  logic       d_req,
  input  logic [7:0] d_addr,
  output logic       d_gnt,
  output logic       d_valid,
  output logic [7:0] rdata,
  output logic [7:0] rom_addr,
  output logic       rom_read,
  output logic       rom_ena,
  input  logic [7:0] rom_data,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [1:0] cnt;
  logic       owner_d;
  logic [7:0] addr_q;
  logic [7:0] rdata_q;
  logic       req_any;
  logic       pick_d;
  logic       last_cnt;

  assign req_any  = f_req | d_req;
  assign last_cnt = (cnt == 2'(ACCESS_CYCLES - 1));

`ifdef ARB_RR_EN
  logic last_d;

  // Round-robin: on contention grant the side that was not granted last
  always_comb begin
    pick_d = d_req & (~f_req | ~last_d);
  end

  // Pointer tracks every grant, contested or not
  always_ff @(posedge clk) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (state == IDLE && req_any) begin
      last_d <= pick_d;
    end
  end
`else
  // Fixed priority: data side always wins
  always_comb begin
    pick_d = d_req;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_any) state_nx = ACCESS;
      ACCESS:  if (last_cnt) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Access datapath: latch winner, count access cycles, capture ROM data
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 2'd0;
      owner_d <= 1'b0;
      addr_q  <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= 2'd0;
          if (req_any) begin
            owner_d <= pick_d;
            addr_q  <= pick_d ? d_addr : f_addr;
          end
        end
        ACCESS: begin
          if (last_cnt) begin
            rdata_q <= rom_data;
            cnt     <= 2'd0;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        default: cnt <= 2'd0;
      endcase
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    f_gnt    = 1'b0;
    d_gnt    = 1'b0;
    f_valid  = 1'b0;
    d_valid  = 1'b0;
    rom_ena  = 1'b0;
    rom_read = 1'b0;
    rom_addr = addr_q;
    rdata    = rdata_q;
    busy     = (state != IDLE);
    unique case (state)
      ACCESS: begin
        rom_ena  = 1'b1;
        rom_read = 1'b1;
        f_gnt    = (cnt == 2'd0) & ~owner_d;
        d_gnt    = (cnt == 2'd0) & owner_d;
      end
      DONE: begin
        f_valid = ~owner_d;
        d_valid = owner_d;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: one instance with 1-cycle access,
// one with 3-cycle access, sharing a behavioural ROM.
module tb_rom_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int ncheck = 0;
  int npass  = 0;

  logic [7:0] mem [256];

  logic       rst1, f_req1, d_req1;
  logic [7:0] f_addr1, d_addr1;
  logic       f_gnt1, f_valid1, d_gnt1, d_valid1;
  logic [7:0] rdata1, rom_addr1;
  wire  [7:0] rom_data1;
  logic       rom_read1, rom_ena1, busy1;

  logic       rst3, f_req3, d_req3;
  logic [7:0] f_addr3, d_addr3;
  logic       f_gnt3, f_valid3, d_gnt3, d_valid3;
  logic [7:0] rdata3, rom_addr3;
  wire  [7:0] rom_data3;
  logic       rom_read3, rom_ena3, busy3;

  assign rom_data1 = rom_ena1 ? mem[rom_addr1] : 8'hzz;
  assign rom_data3 = rom_ena3 ? mem[rom_addr3] : 8'hzz;

  rom_arbiter #(.ACCESS_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst1),
    .f_req(f_req1), .f_addr(f_addr1),
    .f_gnt(f_gnt1), .f_valid(f_valid1),
    .d_req(d_req1), .d_addr(d_addr1),
    .d_gnt(d_gnt1), .d_valid(d_valid1),
    .rdata(rdata1), .rom_addr(rom_addr1),
    .rom_read(rom_read1), .rom_ena(rom_ena1),
    .rom_data(rom_data1), .busy(busy1)
  );

  rom_arbiter #(.ACCESS_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst3),
    .f_req(f_req3), .f_addr(f_addr3),
    .f_gnt(f_gnt3), .f_valid(f_valid3),
    .d_req(d_req3), .d_addr(d_addr3),
    .d_gnt(d_gnt3), .d_valid(d_valid3),
    .rdata(rdata3), .rom_addr(rom_addr3),
    .rom_read(rom_read3), .rom_ena(rom_ena3),
    .rom_data(rom_data3), .busy(busy3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    ncheck++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_zero1(input string tag);
    chk({tag, ".gnt"}, 8'({f_gnt1, d_gnt1}), 8'd0);
    chk({tag, ".vld"}, 8'({f_valid1, d_valid1}), 8'd0);
    chk({tag, ".rom"}, 8'({rom_ena1, rom_read1, busy1}), 8'd0);
    chk({tag, ".rdata"}, rdata1, 8'h00);
    chk({tag, ".addr"}, rom_addr1, 8'h00);
  endtask

  task automatic chk_zero3(input string tag);
    chk({tag, ".gnt"}, 8'({f_gnt3, d_gnt3}), 8'd0);
    chk({tag, ".vld"}, 8'({f_valid3, d_valid3}), 8'd0);
    chk({tag, ".rom"}, 8'({rom_ena3, rom_read3, busy3}), 8'd0);
    chk({tag, ".rdata"}, rdata3, 8'h00);
    chk({tag, ".addr"}, rom_addr3, 8'h00);
  endtask

  initial begin
    logic [7:0] sum;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[1]  = 8'h21;
    mem[2]  = 8'h41;
    mem[65] = 8'h25;
    mem[67] = 8'h35;

    rst1 = 1'b1; f_req1 = 1'b0; d_req1 = 1'b0;
    f_addr1 = 8'h00; d_addr1 = 8'h00;
    rst3 = 1'b1; f_req3 = 1'b0; d_req3 = 1'b0;
    f_addr3 = 8'h00; d_addr3 = 8'h00;
    repeat (2) tick();
    chk_zero1("rst1");
    chk_zero3("rst3");
    rst1 = 1'b0;
    rst3 = 1'b0;
    tick();

    // single fetch, 1-cycle access
    f_req1 = 1'b1; f_addr1 = 8'h01;
    tick();
    chk("f1.gnt", 8'(f_gnt1), 8'd1);
    chk("f1.dgnt", 8'(d_gnt1), 8'd0);
    chk("f1.ena", 8'({rom_ena1, rom_read1}), 8'd3);
    chk("f1.addr", rom_addr1, 8'h01);
    chk("f1.busy", 8'(busy1), 8'd1);
    f_req1 = 1'b0;
    tick();
    chk("f1.vld", 8'(f_valid1), 8'd1);
    chk("f1.rdata", rdata1, 8'h21);
    chk("f1.ena_done", 8'(rom_ena1), 8'd0);
    tick();
    chk("f1.idle", 8'({busy1, f_valid1}), 8'd0);
    chk("f1.hold", rdata1, 8'h21);
    chk("f1.addr_hold", rom_addr1, 8'h01);

    // simultaneous requests, held after grant
    f_req1 = 1'b1; f_addr1 = 8'h02;
    d_req1 = 1'b1; d_addr1 = 8'h41;
    tick();
    chk("sim.dgnt", 8'(d_gnt1), 8'd1);
    chk("sim.fgnt", 8'(f_gnt1), 8'd0);
    chk("sim.addr", rom_addr1, 8'h41);
    tick();
    chk("sim.dvld", 8'(d_valid1), 8'd1);
    chk("sim.rdata", rdata1, 8'h25);
    tick();
    chk("sim.idle", 8'(busy1), 8'd0);
    tick();
`ifdef ARB_RR_EN
    chk("rr.fgnt", 8'(f_gnt1), 8'd1);
    chk("rr.dgnt", 8'(d_gnt1), 8'd0);
    chk("rr.addr", rom_addr1, 8'h02);
    tick();
    chk("rr.fvld", 8'(f_valid1), 8'd1);
    chk("rr.rdata", rdata1, 8'h41);
`else
    chk("fp.dgnt", 8'(d_gnt1), 8'd1);
    chk("fp.fgnt", 8'(f_gnt1), 8'd0);
    chk("fp.addr", rom_addr1, 8'h41);
    tick();
    chk("fp.dvld", 8'(d_valid1), 8'd1);
    chk("fp.rdata", rdata1, 8'h25);
`endif
    f_req1 = 1'b0;
    d_req1 = 1'b0;
    tick();
    chk("sim.end", 8'(busy1), 8'd0);

    // continuous fetch: g, v, idle repeating
    f_req1 = 1'b1; f_addr1 = 8'h01;
    tick();
    for (int i = 0; i < 8; i++) begin
      sum = 8'(f_gnt1) + 8'(d_gnt1) + 8'(f_valid1) + 8'(d_valid1);
      chk("cont.gnt", 8'(f_gnt1), 8'((i % 3) == 0));
      chk("cont.vld", 8'(f_valid1), 8'((i % 3) == 1));
      chk("cont.ena", 8'(rom_ena1), 8'((i % 3) == 0));
      chk("cont.excl", sum, 8'((i % 3) != 2));
      if (i == 7) f_req1 = 1'b0;
      tick();
    end
    chk("cont.end", 8'(busy1), 8'd0);

    // 3-cycle data access
    d_req3 = 1'b1; d_addr3 = 8'h43;
    tick();
    chk("a3.dgnt", 8'(d_gnt3), 8'd1);
    chk("a3.ena1", 8'(rom_ena3), 8'd1);
    chk("a3.addr", rom_addr3, 8'h43);
    d_req3 = 1'b0;
    tick();
    chk("a3.ena2", 8'(rom_ena3), 8'd1);
    chk("a3.gnt2", 8'({d_gnt3, d_valid3}), 8'd0);
    chk("a3.rd2", rdata3, 8'h00);
    tick();
    chk("a3.ena3", 8'(rom_ena3), 8'd1);
    chk("a3.vld3", 8'(d_valid3), 8'd0);
    tick();
    chk("a3.dvld", 8'(d_valid3), 8'd1);
    chk("a3.ena4", 8'(rom_ena3), 8'd0);
    chk("a3.rdata", rdata3, 8'h35);
    tick();
    chk("a3.idle", 8'({busy3, d_valid3}), 8'd0);
    chk("a3.hold", rdata3, 8'h35);

    // reset in the second access cycle of a fetch
    f_req3 = 1'b1; f_addr3 = 8'h01;
    tick();
    chk("ab.fgnt", 8'(f_gnt3), 8'd1);
    f_req3 = 1'b0;
    tick();
    chk("ab.ena2", 8'(rom_ena3), 8'd1);
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    chk_zero3("ab.rst");
    tick();
    chk("ab.nofvld", 8'({f_valid3, busy3}), 8'd0);

    f_req3 = 1'b1; f_addr3 = 8'h01;
    tick();
    chk("pr.fgnt", 8'(f_gnt3), 8'd1);
    chk("pr.addr", rom_addr3, 8'h01);
    f_req3 = 1'b0;
    repeat (2) tick();
    chk("pr.novld", 8'(f_valid3), 8'd0);
    tick();
    chk("pr.fvld", 8'(f_valid3), 8'd1);
    chk("pr.rdata", rdata3, 8'h21);
    tick();
    chk("pr.idle", 8'(busy3), 8'd0);

    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end

endmodule
